// File: rtl/spart_driver.sv
// spart_driver: programs the SPART baud divisor after reset, then echoes received bytes
// through a small FIFO. Optional macro SPART_DRV_CRLF_EN appends LF after every echoed CR.
module spart_driver #(
   parameter logic [15:0] DIV_4800   = 16'd1301,
   parameter logic [15:0] DIV_9600   = 16'd650,
   parameter logic [15:0] DIV_19200  = 16'd325,
   parameter logic [15:0] DIV_38400  = 16'd162,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] br_cfg,
   input  logic       rda,
   input  logic       tbr,
   output logic       iocs,
   output logic       iorw,
   output logic [1:0] ioaddr,
   inout  wire  [7:0] databus,
   output logic       cfg_done,
   output logic       overrun
);

   localparam int          AW      = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_CFG_LOW   = 3'd0,
      S_CFG_HIGH  = 3'd1,
      S_IDLE      = 3'd2,
      S_RD_RX     = 3'd3,
      S_WR_TX     = 3'd4,
      S_HOLD      = 3'd5
`ifdef SPART_DRV_CRLF_EN
      ,
      S_CRLF_WAIT = 3'd6,
      S_WR_LF     = 3'd7
`endif
   } state_t;

   function automatic logic [15:0] div_sel(input logic [1:0] sel);
      logic [15:0] d;
      case (sel)
         2'b00:   d = DIV_4800;
         2'b01:   d = DIV_9600;
         2'b10:   d = DIV_19200;
         2'b11:   d = DIV_38400;
         default: d = DIV_4800;
      endcase
      return d;
   endfunction

   logic [1:0]  r_sync1;
   logic [1:0]  r_sync2;
   logic [1:0]  r_prog;
   state_t      r_state;
   logic        r_iocs;
   logic        r_iorw;
   logic [1:0]  r_ioaddr;
   logic [7:0]  r_wdata;
   logic        r_pop;
   logic        r_cfg_done;
   logic        r_overrun;
   logic [AW:0] r_wp;
   logic [AW:0] r_rp;
   logic [7:0]  r_mem [FIFO_DEPTH];
`ifdef SPART_DRV_CRLF_EN
   logic        r_crlf;
`endif

   logic        w_full;
   logic        w_empty;
   logic        w_pend;
   logic        w_push;
   logic        w_pop;
   logic [7:0]  w_head;
   logic [15:0] w_div;

   assign w_full  = (r_wp[AW-1:0] == r_rp[AW-1:0]) && (r_wp[AW] != r_rp[AW]);
   assign w_empty = (r_wp == r_rp);
   assign w_pend  = (r_sync2 != r_prog);
   // Bus cycles are visible one clock after their state; push/pop at the end of that cycle.
   assign w_push  = r_iocs & r_iorw;
   assign w_pop   = r_iocs & ~r_iorw & r_pop;
   assign w_head  = r_mem[r_rp[AW-1:0]];
   assign w_div   = div_sel(r_prog);

   assign iocs     = r_iocs;
   assign iorw     = r_iorw;
   assign ioaddr   = r_ioaddr;
   assign cfg_done = r_cfg_done;
   assign overrun  = r_overrun;
   assign databus  = (r_iocs && !r_iorw) ? r_wdata : 8'hzz;

   // Two-flop synchronizer for the baud switches
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1 <= 2'b00;
         r_sync2 <= 2'b00;
      end else begin
         r_sync1 <= br_cfg;
         r_sync2 <= r_sync1;
      end
   end

   // Echo FIFO storage and pointers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_mem <= '{default: 8'h00};
      end else begin
         if (w_push) begin
            r_mem[r_wp[AW-1:0]] <= databus;
            r_wp                <= r_wp + PTR_ONE;
         end
         if (w_pop) begin
            r_rp <= r_rp + PTR_ONE;
         end
      end
   end

   // Bus scheduler FSM with registered bus outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_CFG_LOW;
         r_iocs     <= 1'b0;
         r_iorw     <= 1'b1;
         r_ioaddr   <= 2'b00;
         r_wdata    <= 8'h00;
         r_pop      <= 1'b0;
         r_prog     <= 2'b00;
         r_cfg_done <= 1'b0;
         r_overrun  <= 1'b0;
`ifdef SPART_DRV_CRLF_EN
         r_crlf     <= 1'b0;
`endif
      end else begin
         r_iocs   <= 1'b0;
         r_iorw   <= 1'b1;
         r_ioaddr <= 2'b00;
         r_pop    <= 1'b0;
         case (r_state)
            S_CFG_LOW: begin
               r_iocs   <= 1'b1;
               r_iorw   <= 1'b0;
               r_ioaddr <= 2'b10;
               r_wdata  <= w_div[7:0];
               r_state  <= S_CFG_HIGH;
            end
            S_CFG_HIGH: begin
               r_iocs   <= 1'b1;
               r_iorw   <= 1'b0;
               r_ioaddr <= 2'b11;
               r_wdata  <= w_div[15:8];
               r_state  <= S_HOLD;
            end
            S_IDLE: begin
               // Reconfig latches the selection so both divisor bytes come from one table entry
               if (w_pend) begin
                  r_cfg_done <= 1'b0;
                  r_prog     <= r_sync2;
                  r_state    <= S_CFG_LOW;
               end else begin
                  r_cfg_done <= 1'b1;
                  if (rda && w_full) begin
                     r_overrun <= 1'b1;
                  end
                  if (rda && !w_full) begin
                     r_state <= S_RD_RX;
                  end else if (tbr && !w_empty) begin
                     r_state <= S_WR_TX;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            S_RD_RX: begin
               r_iocs  <= 1'b1;
               r_iorw  <= 1'b1;
               r_state <= S_HOLD;
            end
            S_WR_TX: begin
               r_iocs  <= 1'b1;
               r_iorw  <= 1'b0;
               r_wdata <= w_head;
               r_pop   <= 1'b1;
`ifdef SPART_DRV_CRLF_EN
               r_crlf  <= (w_head == 8'h0D);
`endif
               r_state <= S_HOLD;
            end
            S_HOLD: begin
`ifdef SPART_DRV_CRLF_EN
               r_state <= r_crlf ? S_CRLF_WAIT : S_IDLE;
`else
               r_state <= S_IDLE;
`endif
            end
`ifdef SPART_DRV_CRLF_EN
            S_CRLF_WAIT: begin
               if (rda && !w_full) begin
                  r_state <= S_RD_RX;
               end else if (tbr) begin
                  r_state <= S_WR_LF;
               end else begin
                  r_state <= S_CRLF_WAIT;
               end
            end
            S_WR_LF: begin
               r_iocs  <= 1'b1;
               r_iorw  <= 1'b0;
               r_wdata <= 8'h0A;
               r_crlf  <= 1'b0;
               r_state <= S_HOLD;
            end
`endif
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
